// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter
//   Round-robin arbiter sharing one single-port SRAM macro (64x7 class)
//   between NUM_REQ requesters. At most one read or masked-write command
//   is granted per cycle. Read data returns to the issuing requester one
//   cycle after acceptance.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           per-requester command handshake
//   req_we                        per-requester 1 = write, 0 = read
//   req_addr/req_wdata/req_wmask  packed per-requester payloads
//   rsp_valid                     per-requester read response strobe
//   rsp_rdata                     shared read data, qualified by rsp_valid
//   mem_ce/mem_we/mem_addr/
//   mem_wd/mem_w_mask             SRAM pin drive (combinational)
//   mem_rd                        SRAM read data
module sram_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 7
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wmask,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        mem_ce,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wd,
  output logic [DATA_W-1:0]           mem_w_mask,
  input  logic [DATA_W-1:0]           mem_rd
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] rsp_sel_q, rsp_sel_d;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_any;

  // Scan priority offsets 0..NUM_REQ-1 starting at rr_ptr; the inner loop
  // keeps every requester index constant so each select is static.
  // Grants are suppressed while rst is high so the SRAM pins stay quiet.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (!rst) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          if (!gnt_any && req_valid[i] &&
              (i == (32'(rr_ptr_q) + k) % NUM_REQ)) begin
            grant[i] = 1'b1;
            gnt_idx  = PTR_W'(i);
            gnt_any  = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    mem_ce     = gnt_any;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wd     = '0;
    mem_w_mask = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mem_we   = req_we[i];
        mem_addr = req_addr[i*ADDR_W +: ADDR_W];
        if (req_we[i]) begin
          mem_wd     = req_wdata[i*DATA_W +: DATA_W];
          mem_w_mask = req_wmask[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    rsp_sel_d = '0;
    if (gnt_any) begin
      rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      if (!mem_we) begin
        rsp_sel_d = grant;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      rsp_sel_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rsp_sel_q <= rsp_sel_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_sel_q;
  assign rsp_rdata = (|rsp_sel_q) ? mem_rd : '0;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Testbench for sram_rr_arbiter: behavioural SRAM, shadow-memory reference
// model checked every cycle, directed scenarios with literal expectations,
// then a randomized phase with occasional mid-cycle resets.
module tb_sram_rr_arbiter;
  localparam int N  = 2;
  localparam int AW = 6;
  localparam int DW = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, req_wmask;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_ce, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wd, mem_w_mask;
  logic [DW-1:0]   mem_rd = '0;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sram_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_w_mask(mem_w_mask), .mem_rd(mem_rd)
  );

  // Behavioural single-port SRAM attached to the DUT pins.
  logic [DW-1:0] sram [64] = '{default: '0};
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) sram[mem_addr] <= (sram[mem_addr] & ~mem_w_mask) | (mem_wd & mem_w_mask);
      else        mem_rd <= sram[mem_addr];
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: pointer, pending response, shadow memory of commands.
  int            m_ptr = 0;
  int            m_rsp = -1;
  logic [DW-1:0] m_rsp_data = '0;
  logic [DW-1:0] shadow [64] = '{default: '0};

  function automatic int pick();
    if (rst) return -1;
    for (int k = 0; k < N; k++) begin
      int j = (m_ptr + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  int            mg;
  logic [AW-1:0] ma;
  logic [DW-1:0] md, mm;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = 0;
      m_rsp = -1;
    end else begin
      mg    = pick();
      m_rsp = -1;
      if (mg >= 0) begin
        ma = req_addr[mg*AW +: AW];
        md = req_wdata[mg*DW +: DW];
        mm = req_wmask[mg*DW +: DW];
        if (req_we[mg]) shadow[ma] = (shadow[ma] & ~mm) | (md & mm);
        else begin
          m_rsp      = mg;
          m_rsp_data = shadow[ma];
        end
        m_ptr = (mg + 1) % N;
      end
    end
  end

  int  cg;
  logic cw;
  always @(negedge clk) begin
    if (chk_en) begin
      cg = pick();
      cw = (cg >= 0) ? req_we[cg] : 1'b0;
      chk("m_ready", 32'(req_ready), (cg >= 0) ? 32'(1 << cg) : 32'd0);
      chk("m_ce",    32'(mem_ce), (cg >= 0) ? 32'd1 : 32'd0);
      chk("m_we",    32'(mem_we), 32'(cw));
      chk("m_addr",  32'(mem_addr), (cg >= 0) ? 32'(req_addr[cg*AW +: AW]) : 32'd0);
      chk("m_wd",    32'(mem_wd), cw ? 32'(req_wdata[cg*DW +: DW]) : 32'd0);
      chk("m_mask",  32'(mem_w_mask), cw ? 32'(req_wmask[cg*DW +: DW]) : 32'd0);
      chk("m_rspv",  32'(rsp_valid), (m_rsp >= 0) ? 32'(1 << m_rsp) : 32'd0);
      chk("m_rspd",  32'(rsp_rdata), (m_rsp >= 0) ? 32'(m_rsp_data) : 32'd0);
    end
  end

  task automatic set_req(int i, bit v, bit we, int a, int d, int m);
    req_valid[i]          = v;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = AW'(a);
    req_wdata[i*DW +: DW] = DW'(d);
    req_wmask[i*DW +: DW] = DW'(m);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a command on requester i until accepted, then drop valid.
  // Returns 1 ns after the accepting edge.
  task automatic issue(int i, bit we, int a, int d, int m);
    bit ok = 1'b0;
    set_req(i, 1'b1, we, a, d, m);
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) chk("issue_timeout", 32'd0, 32'd1);
    step();
    req_valid[i] = 1'b0;
  endtask

  logic [N-1:0] gp;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
    @(posedge clk);
    #2 chk_en = 1'b1;
    @(negedge clk);
    chk("reset_rspv", 32'(rsp_valid), 32'd0);
    chk("reset_rspd", 32'(rsp_rdata), 32'd0);
    chk("reset_ce",   32'(mem_ce), 32'd0);
    chk("reset_addr", 32'(mem_addr), 32'd0);
    step();
    rst = 1'b0;

    // Single write then read
    issue(0, 1, 5, 'h55, 'h7F);
    @(negedge clk);
    chk("wr_norsp", 32'(rsp_valid), 32'd0);
    step();
    issue(0, 0, 5, 0, 0);
    @(negedge clk);
    chk("rd_rspv", 32'(rsp_valid), 32'd1);
    chk("rd_rspd", 32'(rsp_rdata), 32'h55);
    step();

    // Masked write, read-after-write back to back
    issue(0, 1, 9, 'h00, 'h7F);
    issue(0, 1, 9, 'h7F, 'h0F);
    issue(0, 0, 9, 0, 0);
    @(negedge clk);
    chk("mask_rspd", 32'(rsp_rdata), 32'h0F);
    step();

    // Contention: a grant to requester 1 first puts the pointer at 0
    issue(1, 0, 5, 0, 0);
    set_req(0, 1, 0, 5, 0, 0);
    set_req(1, 1, 0, 9, 0, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_ce", 32'(mem_ce), 32'd1);
      if (k > 0) chk("rr_rspv", 32'(rsp_valid), (k % 2 == 0) ? 32'd2 : 32'd1);
      step();
    end
    req_valid = '0;

    // Idle with pointer hold
    repeat (3) begin
      @(negedge clk);
      chk("idle_ce",   32'(mem_ce), 32'd0);
      chk("idle_addr", 32'(mem_addr), 32'd0);
      step();
    end
    set_req(0, 1, 0, 5, 0, 0);
    set_req(1, 1, 0, 9, 0, 0);
    @(negedge clk);
    chk("hold_grant", 32'(req_ready), 32'd1);
    step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    step();
    req_valid = '0;

    // Address boundaries
    issue(0, 1, 63, 'h3A, 'h7F);
    issue(1, 1, 0, 'h45, 'h7F);
    issue(0, 0, 63, 0, 0);
    @(negedge clk);
    chk("wrap_hi", 32'(rsp_rdata), 32'h3A);
    step();
    issue(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("wrap_lo", 32'(rsp_rdata), 32'h45);
    step();

    // Reset mid-operation
    issue(0, 0, 5, 0, 0);
    chk("pre_rst_rspv", 32'(rsp_valid), 32'd1);
    #2 rst = 1'b1;
    #1 chk("rst_rspv", 32'(rsp_valid), 32'd0);
    set_req(0, 1, 0, 9, 0, 0);
    set_req(1, 1, 0, 5, 0, 0);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_ce",    32'(mem_ce), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_grant", 32'(req_ready), 32'd1);
    step();
    req_valid[0] = 1'b0;
    @(negedge clk);
    step();
    req_valid = '0;

    // Randomized traffic honouring the hold-until-ready rule
    repeat (1500) begin
      @(negedge clk);
      gp = req_ready;
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || gp[i]) begin
          set_req(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 63 : int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
        end
      end
    end
    rst = 1'b0;
    req_valid = '0;
    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_rr_arbiter.md
# sram_rr_arbiter

Round-robin arbiter that shares one single-port 64x7 SRAM macro (fakeram45_64x7 class: `ce_in`, `we_in`, 6-bit `addr_in`, 7-bit `wd_in`, 7-bit `w_mask_in`, 7-bit `rd_out`) between NUM_REQ requesters. Each requester issues read or masked-write commands over a valid/ready handshake, and the arbiter grants at most one command per cycle. Read data returns to the issuing requester exactly one cycle after acceptance. The block sits between the requesting logic and the memory hierarchy instance, replacing direct tie-off or hard-wired drive of the macro pins.

## Interface
- NUM_REQ, 2: number of requesters, 2..4.
- ADDR_W, 6: SRAM address width.
- DATA_W, 7: SRAM data and mask width.

Ports:
- clk  in  1  single clock; all state is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  command valid, one bit per requester.
- req_ready  out  NUM_REQ  command accepted this cycle (grant).
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i is at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_wmask  in  NUM_REQ*DATA_W  packed bit-write mask; 1 = write that bit.
- rsp_valid  out  NUM_REQ  read data valid for requester i.
- rsp_rdata  out  DATA_W  read data; shared by all requesters, qualified by rsp_valid.
- mem_ce  out  1  to SRAM `ce_in`, active-high.
- mem_we  out  1  to SRAM `we_in`, active-high.
- mem_addr  out  ADDR_W  to `addr_in`.
- mem_wd  out  DATA_W  to `wd_in`.
- mem_w_mask  out  DATA_W  to `w_mask_in`.
- mem_rd  in  DATA_W  from `rd_out`.

## Operation
- **State**
  - Round-robin pointer `rr_ptr` (0..NUM_REQ-1).
  - Response register `rsp_sel`: one-hot of NUM_REQ, or zero.
- **Arbitration** (combinational)
  - Scan requesters starting at `rr_ptr`, wrapping modulo NUM_REQ.
  - The first one with `req_valid=1` is granted: its `req_ready=1`; all other `req_ready` bits are 0.
  - `req_ready` never asserts without the matching `req_valid`.
- **Handshake rule**: a requester holds `req_valid` and its payload stable until it sees `req_ready`. The arbiter does not check this rule.
- **Memory drive** (combinational from the granted requester)
  - `mem_ce=1`.
  - `mem_we=req_we[g]`.
  - `mem_addr`, `mem_wd`, `mem_w_mask` come from requester g.
  - With no grant, all memory outputs are 0.
  - For a read, `mem_w_mask` and `mem_wd` are forced to 0.
- **Pointer update**: on each grant to g, `rr_ptr <= (g+1) mod NUM_REQ`. With no grant, `rr_ptr` holds.
- **Responses**
  - On a granted read, `rsp_sel <= onehot(g)`. Otherwise `rsp_sel <= 0`.
  - `rsp_valid = rsp_sel`.
  - `rsp_rdata = mem_rd` when any `rsp_valid` is set, else 0.
  - Writes produce no response.
- **No backpressure on responses**: a requester must consume `rsp_rdata` in the cycle `rsp_valid` is high.
- **Read-after-write**: a read accepted the cycle after a write to the same address returns the newly written bits (masked bits only; unmasked bits keep their old value).
- **Reset**
  - `rst=1` immediately (asynchronously) drives `rr_ptr=0` and `rsp_sel=0`.
  - While `rst=1`, `req_ready=0` and `mem_ce=0`. A read accepted just before reset asserts gets no response.

## Timing
- Accept in cycle T (valid&ready at clk edge T). The SRAM samples its pins at the same edge.
- Read response: `rsp_valid` is high during cycle T+1 only, and `rsp_rdata` is valid in that cycle.
- Throughput: one command per cycle. Back-to-back reads from different requesters produce back-to-back responses.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- Reset values:
  - `req_ready=0`, `rsp_valid=0`, `rsp_rdata=0`.
  - `mem_ce=0`, `mem_we=0`, `mem_addr=0`, `mem_wd=0`, `mem_w_mask=0`.
- First grant after reset release goes to requester 0 if it is valid.

## Test plan
1. **Single write then read**: requester 0 writes addr 5, wdata 7'h55, mask 7'h7F; then reads addr 5 → `rsp_valid=2'b01` one cycle after the read is accepted, `rsp_rdata=7'h55`; `rsp_valid` stays 0 after the write.
2. **Masked write**: addr 9 preloaded with 7'h00; write 7'h7F with mask 7'h0F; then read addr 9 → `rsp_rdata=7'h0F`.
3. **Contention round-robin**: both requesters valid with reads for 6 cycles → grants alternate 0,1,0,1,0,1; `rsp_valid` alternates 01,10,… one cycle later; `mem_ce` stays high throughout.
4. **Idle and pointer hold**: grant to requester 1, 3 idle cycles, then both valid → requester 0 is granted first; `mem_ce=0` and `mem_addr=0` during the idle cycles.
5. **Address wrap / boundary**: write addr 63 with 7'h3A and addr 0 with 7'h45; read both → 7'h3A and 7'h45, with no aliasing between them.
6. **Reset mid-operation**: read accepted at edge T; assert `rst` asynchronously before edge T+1 → `rsp_valid` goes to 0 immediately and no response is issued. After release, with both requesters valid, requester 0 is granted first.
